// File: rtl/spmv_fp_mul_pipe.sv
// Pipelined IEEE-754-style multiplier (RNE, flush-to-zero); optional {NV,OF,UF,NX} output via SPMV_FP_MUL_FLAGS_EN.
// Latency 3 cycles, 1 result/cycle; the whole pipe stalls while a result is held (o_ready = i_ready | ~o_valid).
module spmv_fp_mul_pipe #(
   parameter int EXP_W = 5,
   parameter int MAN_W = 10,
   parameter int TAG_W = 8
) (
   input  logic                 i_clk,
   input  logic                 i_rstn,
   input  logic                 i_valid,
   output logic                 o_ready,
   input  logic [EXP_W+MAN_W:0] i_vector,
   input  logic [EXP_W+MAN_W:0] i_value,
   input  logic [TAG_W-1:0]     i_tag,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic [EXP_W+MAN_W:0] o_result,
`ifdef SPMV_FP_MUL_FLAGS_EN
   output logic [3:0]           o_flags,
`endif
   output logic [TAG_W-1:0]     o_tag
);
   localparam int W   = 1 + EXP_W + MAN_W;
   localparam int EW2 = EXP_W + 2;
   localparam int PW  = 2 * MAN_W + 2;
   localparam logic signed [EW2-1:0] BIAS = EW2'((1 << (EXP_W - 1)) - 1);
   localparam logic signed [EW2-1:0] EMAX = EW2'((1 << EXP_W) - 1);

   logic en;
   assign en      = i_ready | ~o_valid;
   assign o_ready = en;

   logic             s_a, s_b;
   logic [EXP_W-1:0] e_a, e_b;
   logic [MAN_W-1:0] f_a, f_b;
   assign {s_a, e_a, f_a} = i_vector;
   assign {s_b, e_b, f_b} = i_value;

   // Subnormals land in the zero class because only the exponent is tested.
   logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
   assign a_zero = (e_a == '0);
   assign b_zero = (e_b == '0);
   assign a_inf  = (&e_a) & ~(|f_a);
   assign b_inf  = (&e_b) & ~(|f_b);
   assign a_nan  = (&e_a) & (|f_a);
   assign b_nan  = (&e_b) & (|f_b);

   logic signed [EW2-1:0] u_exp;
   assign u_exp = $signed({2'b00, e_a}) + $signed({2'b00, e_b}) - BIAS;

   logic                  s1_vld, s1_sign, s1_nan, s1_inf, s1_zero;
   logic signed [EW2-1:0] s1_exp;
   logic [MAN_W:0]        s1_ma, s1_mb;
   logic [TAG_W-1:0]      s1_tag;
   logic                  s2_vld, s2_sign, s2_nan, s2_inf, s2_zero;
   logic signed [EW2-1:0] s2_exp;
   logic [PW-1:0]         s2_prod;
   logic [TAG_W-1:0]      s2_tag;

   logic             norm_hi, guard, sticky, rnd_up, m_carry;
   logic [MAN_W-1:0] frac_k, frac_r;
   assign norm_hi = s2_prod[PW-1];

   always_comb begin
      if (norm_hi) begin
         frac_k = s2_prod[PW-2:MAN_W+1];
         guard  = s2_prod[MAN_W];
         sticky = |s2_prod[MAN_W-1:0];
      end else begin
         frac_k = s2_prod[PW-3:MAN_W];
         guard  = s2_prod[MAN_W-1];
         sticky = |s2_prod[MAN_W-2:0];
      end
   end

   assign rnd_up            = guard & (sticky | frac_k[0]);
   assign {m_carry, frac_r} = {1'b0, frac_k} + (MAN_W + 1)'(rnd_up);

   logic signed [EW2-1:0] exp_f;
   logic                  ovf, unf;
   assign exp_f = s2_exp + $signed(EW2'(norm_hi)) + $signed(EW2'(m_carry));
   assign ovf   = exp_f >= EMAX;
   assign unf   = exp_f[EW2-1] | (exp_f == '0);

   logic [W-1:0] r_res;
   always_comb begin
      r_res = '0;
      if (s2_nan)
         r_res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      else if (s2_inf)
         r_res = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      else if (s2_zero)
         r_res = {s2_sign, {(W-1){1'b0}}};
      else if (ovf)
         r_res = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      else if (unf)
         r_res = {s2_sign, {(W-1){1'b0}}};
      else
         r_res = {s2_sign, exp_f[EXP_W-1:0], frac_r};
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         s1_vld   <= 1'b0;
         s1_sign  <= 1'b0;
         s1_nan   <= 1'b0;
         s1_inf   <= 1'b0;
         s1_zero  <= 1'b0;
         s1_exp   <= '0;
         s1_ma    <= '0;
         s1_mb    <= '0;
         s1_tag   <= '0;
         s2_vld   <= 1'b0;
         s2_sign  <= 1'b0;
         s2_nan   <= 1'b0;
         s2_inf   <= 1'b0;
         s2_zero  <= 1'b0;
         s2_exp   <= '0;
         s2_prod  <= '0;
         s2_tag   <= '0;
         o_valid  <= 1'b0;
         o_result <= '0;
         o_tag    <= '0;
      end else if (en) begin
         s1_vld   <= i_valid;
         s1_sign  <= s_a ^ s_b;
         s1_nan   <= a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
         s1_inf   <= a_inf | b_inf;
         s1_zero  <= a_zero | b_zero;
         s1_exp   <= u_exp;
         s1_ma    <= {1'b1, f_a};
         s1_mb    <= {1'b1, f_b};
         s1_tag   <= i_tag;
         s2_vld   <= s1_vld;
         s2_sign  <= s1_sign;
         s2_nan   <= s1_nan;
         s2_inf   <= s1_inf;
         s2_zero  <= s1_zero;
         s2_exp   <= s1_exp;
         s2_prod  <= PW'(s1_ma) * PW'(s1_mb);
         s2_tag   <= s1_tag;
         o_valid  <= s2_vld;
         o_result <= r_res;
         o_tag    <= s2_tag;
      end
   end

`ifdef SPMV_FP_MUL_FLAGS_EN
   // Only finite-operand results can overflow, underflow or be inexact.
   logic       fin;
   logic [3:0] r_flags;
   assign fin     = ~(s2_nan | s2_inf | s2_zero);
   assign r_flags = {s2_nan, fin & ovf, fin & unf, fin & (ovf | unf | guard | sticky)};

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn)
         o_flags <= '0;
      else if (en)
         o_flags <= r_flags;
   end
`endif
endmodule

// File: tb/tb_spmv_fp_mul_pipe.sv
// Bench for spmv_fp_mul_pipe: fp16 and fp32 instances against an exact-integer product model.
module tb_spmv_fp_mul_pipe;
   logic clk;
   logic rstn;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic        v_vld, v_rdy, o_vld, d_rdy;
   logic [15:0] a16, b16, res16;
   logic [7:0]  tag16, otag16;
   logic [3:0]  fl16;
   logic        h_vld, h_ordy, h_ovld, h_rdy;
   logic [31:0] a32, b32, res32;
   logic [7:0]  tag32, otag32;
   logic [3:0]  fl32;

   spmv_fp_mul_pipe u_dut16 (
      .i_clk(clk), .i_rstn(rstn), .i_valid(v_vld), .o_ready(v_rdy),
      .i_vector(a16), .i_value(b16), .i_tag(tag16),
      .o_valid(o_vld), .i_ready(d_rdy), .o_result(res16),
`ifdef SPMV_FP_MUL_FLAGS_EN
      .o_flags(fl16),
`endif
      .o_tag(otag16));

   spmv_fp_mul_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(8)) u_dut32 (
      .i_clk(clk), .i_rstn(rstn), .i_valid(h_vld), .o_ready(h_ordy),
      .i_vector(a32), .i_value(b32), .i_tag(tag32),
      .o_valid(h_ovld), .i_ready(h_rdy), .o_result(res32),
`ifdef SPMV_FP_MUL_FLAGS_EN
      .o_flags(fl32),
`endif
      .o_tag(otag32));

`ifndef SPMV_FP_MUL_FLAGS_EN
   assign fl16 = 4'h0;
   assign fl32 = 4'h0;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   int out_cnt = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: exact integer product, explicit remainder-vs-half rounding. Returns {NV,OF,UF,NX,result}.
   function automatic logic [35:0] fpmul(input int ew, input int mw, input logic [31:0] a, input logic [31:0] b);
      longint one, emax, bias, fmask, la, lb, ea, eb, fa, fb, sgn, p, q, rem, half, e;
      int     sh;
      logic   nv, ofl, ufl, nx, a_nan, b_nan, a_inf, b_inf, a_z, b_z;
      logic [31:0] r;
      one = 1; la = a; lb = b;
      emax  = (one << ew) - 1;
      bias  = (one << (ew - 1)) - 1;
      fmask = (one << mw) - 1;
      ea = (la >> mw) & emax;  fa = la & fmask;
      eb = (lb >> mw) & emax;  fb = lb & fmask;
      sgn = ((la >> (ew + mw)) ^ (lb >> (ew + mw))) & 1;
      a_nan = (ea == emax) && (fa != 0);  b_nan = (eb == emax) && (fb != 0);
      a_inf = (ea == emax) && (fa == 0);  b_inf = (eb == emax) && (fb == 0);
      a_z = (ea == 0);  b_z = (eb == 0);
      nv = 0; ofl = 0; ufl = 0; nx = 0;
      if (a_nan || b_nan || (a_inf && b_z) || (b_inf && a_z)) begin
         r = 32'((emax << mw) | (one << (mw - 1)));
         nv = 1;
      end else if (a_inf || b_inf) begin
         r = 32'((sgn << (ew + mw)) | (emax << mw));
      end else if (a_z || b_z) begin
         r = 32'(sgn << (ew + mw));
      end else begin
         p  = (fa | (one << mw)) * (fb | (one << mw));
         sh = (p >= (one << (2 * mw + 1))) ? mw + 1 : mw;
         e  = ea + eb - bias + sh - mw;
         q  = p >> sh;
         rem  = p - (q << sh);
         half = one << (sh - 1);
         if (rem > half || (rem == half && (q & 1) == 1)) q = q + 1;
         if (q == (one << (mw + 1))) begin
            q = q >> 1;
            e = e + 1;
         end
         nx = (rem != 0);
         if (e >= emax) begin
            r = 32'((sgn << (ew + mw)) | (emax << mw));
            ofl = 1; nx = 1;
         end else if (e <= 0) begin
            r = 32'(sgn << (ew + mw));
            ufl = 1; nx = 1;
         end else begin
            r = 32'((sgn << (ew + mw)) | (e << mw) | (q - (one << mw)));
         end
      end
      return {nv, ofl, ufl, nx, r};
   endfunction

   typedef struct packed {
      logic [15:0] res;
      logic [7:0]  tag;
      logic [3:0]  fl;
   } exp_t;
   exp_t        exp_q[$];
   logic        stall_prev = 1'b0;
   logic [23:0] held;

   // Inputs change only just after posedge, so the negedge view is exactly what the next edge transfers.
   always @(negedge clk) begin
      logic [35:0] m;
      exp_t        e;
      if (!rstn) begin
         exp_q.delete();
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) check("stall_hold", {res16, otag16}, held);
         if (o_vld && d_rdy) begin
            out_cnt++;
            if (exp_q.size() == 0) begin
               check("spurious_out", o_vld, 1'b0);
            end else begin
               e = exp_q.pop_front();
               check("result16", res16, e.res);
               check("tag16", otag16, e.tag);
`ifdef SPMV_FP_MUL_FLAGS_EN
               check("flags16", fl16, e.fl);
`endif
            end
         end
         if (v_vld && v_rdy) begin
            m = fpmul(5, 10, {16'h0, a16}, {16'h0, b16});
            exp_q.push_back({m[15:0], tag16, m[35:32]});
         end
         stall_prev = o_vld && !d_rdy;
         held = {res16, otag16};
      end
   end

   task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [7:0] t);
      logic acc;
      int   n;
      a16 = a; b16 = b; tag16 = t; v_vld = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         acc = v_rdy;
         @(posedge clk);
         #1;
         n++;
      end while (!acc && n < 200);
      if (!acc) check("send_timeout", acc, 1'b1);
      v_vld = 1'b0;
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [15:0] rnd_op();
      logic [4:0] e;
      logic [9:0] f;
      f = 10'($urandom);
      case ($urandom_range(0, 7))
         0:       e = 5'h00;
         1:       e = 5'h1f;
         2:       e = 5'($urandom_range(1, 4));
         3:       e = 5'($urandom_range(26, 30));
         default: e = 5'($urandom_range(8, 22));
      endcase
      if ($urandom_range(0, 5) == 0) f = '0;
      return {1'($urandom), e, f};
   endfunction

   task automatic mul32(input logic [31:0] a, input logic [31:0] b, input logic [7:0] t, input string nm);
      logic [35:0] m;
      int          n;
      m = fpmul(8, 23, a, b);
      a32 = a; b32 = b; tag32 = t; h_vld = 1'b1;
      tick(1);
      h_vld = 1'b0;
      n = 1;
      while (!h_ovld && n < 10) begin
         tick(1);
         n++;
      end
      check({nm, "_valid"}, h_ovld, 1'b1);
      check(nm, res32, m[31:0]);
      check({nm, "_tag"}, otag32, t);
`ifdef SPMV_FP_MUL_FLAGS_EN
      check({nm, "_flags"}, fl32, m[35:32]);
`endif
      tick(1);
   endtask

   localparam int ND = 9;
   logic [15:0] dir_a  [ND] = '{16'h3C01, 16'h3C01, 16'h7BFF, 16'h7C00, 16'hFC00, 16'h7E00, 16'h0400, 16'h8400, 16'h0001};
   logic [15:0] dir_b  [ND] = '{16'h3C01, 16'h3E00, 16'h7BFF, 16'h0000, 16'h4000, 16'h3C00, 16'h3800, 16'h3800, 16'h3C00};
   logic [15:0] dir_r  [ND] = '{16'h3C02, 16'h3E02, 16'h7C00, 16'h7E00, 16'hFC00, 16'h7E00, 16'h0000, 16'h8000, 16'h0000};
   logic [3:0]  dir_f  [ND] = '{4'b0001,  4'b0001,  4'b0101,  4'b1000,  4'b0000,  4'b1000,  4'b0011,  4'b0011,  4'b0000};

   logic rnd_rdy_on = 1'b0;
   always @(posedge clk) begin
      if (rnd_rdy_on) begin
         #1;
         d_rdy = ($urandom_range(0, 9) < 7);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [35:0] m;
      int          n, c0;
      v_vld = 0; a16 = 0; b16 = 0; tag16 = 0; d_rdy = 1;
      h_vld = 0; a32 = 0; b32 = 0; tag32 = 0; h_rdy = 1;
      rstn = 1'b1;
      #1 rstn = 1'b0;
      #12;
      check("rst_ovalid", o_vld, 1'b0);
      check("rst_result", res16, 16'h0);
      check("rst_tag", otag16, 8'h0);
      check("rst_flags", fl16, 4'h0);
      check("rst_oready", v_rdy, 1'b1);
      @(posedge clk);
      #3 rstn = 1'b1;
      tick(2);

      // Pin the model with hand-derived values.
      m = fpmul(5, 10, 32'h4C00, 32'h4000);      check("model_basic", m, {4'b0000, 32'h5000});
      m = fpmul(5, 10, 32'h3C01, 32'h3E00);      check("model_tie", m, {4'b0001, 32'h3E02});
      m = fpmul(5, 10, 32'h7BFF, 32'h7BFF);      check("model_ovf", m, {4'b0101, 32'h7C00});
      m = fpmul(5, 10, 32'h7C00, 32'h0000);      check("model_nv", m, {4'b1000, 32'h7E00});
      m = fpmul(5, 10, 32'h8400, 32'h3800);      check("model_uf", m, {4'b0011, 32'h8000});
      m = fpmul(8, 23, 32'h41800000, 32'h40000000); check("model_fp32", m, {4'b0000, 32'h42000000});

      // Basic product with exact latency.
      a16 = 16'h4C00; b16 = 16'h4000; tag16 = 8'h05; v_vld = 1'b1;
      tick(1);
      v_vld = 1'b0;
      check("lat_c1", o_vld, 1'b0);
      tick(1);
      check("lat_c2", o_vld, 1'b0);
      tick(1);
      check("lat_c3", o_vld, 1'b1);
      check("basic_result", res16, 16'h5000);
      check("basic_tag", otag16, 8'h05);
      check("basic_flags", fl16, 4'h0);
      tick(1);

      for (int i = 0; i < ND; i++) begin
         send(dir_a[i], dir_b[i], 8'(8'h10 + i));
         tick(2);
         check("dir_valid", o_vld, 1'b1);
         check("dir_result", res16, dir_r[i]);
`ifdef SPMV_FP_MUL_FLAGS_EN
         check("dir_flags", fl16, dir_f[i]);
`endif
         tick(1);
      end

      // Back-pressure with a full pipe.
      d_rdy = 1'b0;
      c0 = out_cnt;
      fork
         begin
            for (int i = 1; i <= 6; i++) send(16'(16'h3C00 + i * 7), 16'h4100, 8'(i));
         end
         begin
            int w;
            w = 0;
            while (!o_vld && w < 50) begin
               tick(1);
               w++;
            end
            check("bp_ovalid_rise", o_vld, 1'b1);
            for (int k = 0; k < 5; k++) begin
               @(negedge clk);
               check("bp_oready_low", v_rdy, 1'b0);
               @(posedge clk);
               #1;
            end
            d_rdy = 1'b1;
         end
      join
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         tick(1);
         n++;
      end
      tick(1);
      check("bp_drained", exp_q.size(), 0);
      check("bp_count", out_cnt - c0, 6);

      // Asynchronous reset with items in flight.
      send(16'h4000, 16'h4000, 8'hA1);
      send(16'h4200, 16'h4000, 8'hA2);
      send(16'h4400, 16'h4000, 8'hA3);
      #1 rstn = 1'b0;
      #1;
      check("arst_ovalid", o_vld, 1'b0);
      check("arst_result", res16, 16'h0);
      check("arst_tag", otag16, 8'h0);
      @(negedge clk);
      @(posedge clk);
      #3 rstn = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick(1);
         check("arst_no_stale", o_vld, 1'b0);
      end

      // Randomised traffic with random gaps and random downstream stalls.
      rnd_rdy_on = 1'b1;
      c0 = out_cnt;
      for (int i = 0; i < 1500; i++) begin
         send(rnd_op(), rnd_op(), 8'(i));
         if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 3));
      end
      rnd_rdy_on = 1'b0;
      tick(1);
      d_rdy = 1'b1;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         tick(1);
         n++;
      end
      tick(1);
      check("rnd_drained", exp_q.size(), 0);
      check("rnd_count", out_cnt - c0, 1500);

      // fp32 instance.
      mul32(32'h41800000, 32'h40000000, 8'h05, "fp32_basic");
      check("fp32_literal", res32, 32'h42000000);
      mul32(32'h7F800000, 32'h00000000, 8'h06, "fp32_nv");
      for (int i = 0; i < 20; i++) begin
         logic [31:0] ra, rb;
         ra = {1'($urandom), 8'($urandom_range(90, 165)), 23'($urandom)};
         rb = {1'($urandom), 8'($urandom_range(90, 165)), 23'($urandom)};
         if (i == 3) ra[30:23] = 8'hFF;
         if (i == 7) rb[30:23] = 8'h00;
         if (i == 11) ra[30:23] = 8'hFE;
         mul32(ra, rb, 8'(i), "fp32_rnd");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
